neuron_step_scheduler: RTL and testbench
========================================

NEURON_STEP_SCHEDULER -- requirements
Module: neuron_step_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of neuron state slots that share one update datapath.
REQ-002 Parameter W, default 16: width of every state, current and dt word.
REQ-003 Parameter TIMEOUT, default 255: maximum number of WAIT cycles allowed per neuron.
REQ-004 Parameter SPIKE_TH, default 0 (signed): spike threshold on V.
REQ-005 Ports, given as name  direction  width  meaning:
  - clock  in  1  single clock.
  - reset  in  1  asynchronous, active-low reset.
  - step_req  in  1  one-cycle request to run one timestep over all neurons.
  - dt  in  W  timestep, sampled when a step is accepted.
  - cur_wr_en  in  1  write strobe for a per-neuron current.
  - cur_wr_addr  in  log2(N)  target neuron for the current write.
  - cur_wr_data  in  W  current value to write.
  - dp_valid  out  1  operand-valid to the datapath.
  - dp_ready  in  1  datapath accepts operands.
  - dp_v, dp_m, dp_h, dp_n, dp_i, dp_dt  out  W each  operands.
  - dp_res_valid  in  1  result-valid from the datapath.
  - dp_res_v, dp_res_m, dp_res_h, dp_res_n  in  W each  results.
  - sel  in  log2(N)  neuron selected for readout.
  - data_out  out  W  V of neuron sel.
  - busy  out  1  step in progress.
  - step_done  out  1  one-cycle pulse at step completion.
  - spike  out  N  per-neuron upward threshold crossing during the last step.
  - timeout_err  out  1  sticky flag, set on any datapath timeout.

Function
REQ-006 Each neuron slot SHALL hold signed V and unsigned m, h, n (W bits each), plus current I (W bits).
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-008 In IDLE, step_req=1 SHALL latch dt, clear the neuron index, clear spike, and move to ISSUE on the next cycle.
REQ-009 step_req received while busy=1 SHALL be ignored.
REQ-010 In ISSUE, dp_valid SHALL be 1 with the operands of the current neuron; the operands SHALL be held stable until dp_ready=1, after which the FSM moves to WAIT.
REQ-011 In WAIT, dp_res_valid=1 SHALL write dp_res_* into the current slot in that same clock edge.
  - If V_old < SPIKE_TH and dp_res_v >= SPIKE_TH (signed compare), spike[idx] SHALL be set.
  - The index then increments and the FSM moves to ISSUE, or to DONE after neuron N-1.
REQ-012 If WAIT lasts TIMEOUT cycles without dp_res_valid:
  - the slot SHALL be left unchanged;
  - timeout_err SHALL be set;
  - the FSM SHALL advance exactly as in REQ-011.
REQ-013 dp_res_valid asserted outside WAIT SHALL be ignored.
REQ-014 DONE SHALL last one cycle, assert step_done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in ISSUE, WAIT and DONE.
REQ-016 A current write SHALL update I[cur_wr_addr] at the clock edge.
  - A write coinciding with that neuron's ISSUE cycle SHALL still present the old I.
  - The new value SHALL apply from the next step.
REQ-017 data_out SHALL be the registered V[sel], updated one cycle after sel or the slot changes.
REQ-018 Minimum step latency SHALL be 2N+2 cycles from step_req to step_done, with zero-wait dp_ready and dp_res_valid.

Reset
REQ-019 When reset=0, the block SHALL asynchronously force:
  - state IDLE and index 0;
  - every V = -65 (0xFFBF), m = 0, h = 1, n = 0, I = 0;
  - data_out = 0xFFBF;
  - dp_valid, busy, step_done, spike and timeout_err = 0.
REQ-020 Reset asserted mid-step SHALL abandon the step; no partial write-back is permitted after release.

Structure
REQ-021 The state encoding, the reset constants V_REST/M_INIT/H_INIT/N_INIT and the default parameters SHALL live in the shared neuron package.
REQ-022 The per-neuron state storage SHALL be one sub-module, neuron_state_bank, with one write port and two read ports (issue and readout).

Verification
REQ-023 Reset release then sel=2 -> data_out=0xFFBF, busy=0, spike=0.
REQ-024 Write I[1]=100, step_req, with a datapath stub returning V+10 after 3 cycles -> four write-backs in index order, step_done once, every V=-55.
REQ-025 Stub returning V=5 from V_old=-65 for neuron 3 only -> spike=4'b1000 at step_done.
REQ-026 Stub never asserts dp_res_valid for neuron 0 with TIMEOUT=8 -> timeout_err=1, V[0] unchanged, neurons 1-3 updated, step_done asserted.
REQ-027 dp_ready held low 5 cycles -> dp_v..dp_dt stable across all 5 cycles; a second step_req while busy -> no extra step.
REQ-028 reset pulsed low during WAIT of neuron 2 -> all slots return to initial values and a subsequent late dp_res_valid is ignored.

Source files
------------

// File: rtl/neuron_step_scheduler_pkg.sv
// Shared constants, FSM encoding and defaults for the neuron step scheduler.
// Reset values model a resting membrane: V = -65, h fully open, m and n closed.
package neuron_step_scheduler_pkg;

  localparam int unsigned NNeuronsDefault = 4;
  localparam int unsigned WDefault        = 16;
  localparam int unsigned TimeoutDefault  = 255;
  localparam int          SpikeThDefault  = 0;

  localparam int V_REST = -65;
  localparam int M_INIT = 0;
  localparam int H_INIT = 1;
  localparam int N_INIT = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_state_bank.sv
// Per-neuron V/m/h/n/I storage: one state write port, one current write port,
// a combinational issue read port and a registered readout port.
module neuron_state_bank
  import neuron_step_scheduler_pkg::*;
#(
  parameter int unsigned N_NEURONS = NNeuronsDefault,
  parameter int unsigned W         = WDefault,
  localparam int unsigned IdxW     = idx_width(N_NEURONS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [W-1:0]    wr_v_i,
  input  logic [W-1:0]    wr_m_i,
  input  logic [W-1:0]    wr_h_i,
  input  logic [W-1:0]    wr_n_i,
  input  logic            cur_wr_en_i,
  input  logic [IdxW-1:0] cur_wr_addr_i,
  input  logic [W-1:0]    cur_wr_data_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [W-1:0]    rd_v_o,
  output logic [W-1:0]    rd_m_o,
  output logic [W-1:0]    rd_h_o,
  output logic [W-1:0]    rd_n_o,
  output logic [W-1:0]    rd_i_o,
  input  logic [IdxW-1:0] sel_i,
  output logic [W-1:0]    data_o
);

  logic [W-1:0] v_q [N_NEURONS];
  logic [W-1:0] m_q [N_NEURONS];
  logic [W-1:0] h_q [N_NEURONS];
  logic [W-1:0] n_q [N_NEURONS];
  logic [W-1:0] i_q [N_NEURONS];
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(N_NEURONS); k++) begin
        v_q[k] <= W'(V_REST);
        m_q[k] <= W'(M_INIT);
        h_q[k] <= W'(H_INIT);
        n_q[k] <= W'(N_INIT);
        i_q[k] <= '0;
      end
      data_q <= W'(V_REST);
    end else begin
      if (wr_en_i) begin
        v_q[wr_idx_i] <= wr_v_i;
        m_q[wr_idx_i] <= wr_m_i;
        h_q[wr_idx_i] <= wr_h_i;
        n_q[wr_idx_i] <= wr_n_i;
      end
      if (cur_wr_en_i) begin
        i_q[cur_wr_addr_i] <= cur_wr_data_i;
      end
      data_q <= v_q[sel_i];
    end
  end

  assign rd_v_o = v_q[rd_idx_i];
  assign rd_m_o = m_q[rd_idx_i];
  assign rd_h_o = h_q[rd_idx_i];
  assign rd_n_o = n_q[rd_idx_i];
  assign rd_i_o = i_q[rd_idx_i];
  assign data_o = data_q;

endmodule

// File: rtl/neuron_step_scheduler.sv
// Walks every neuron slot through a shared update datapath once per timestep,
// with per-neuron result timeout, spike detection and registered V readout.
module neuron_step_scheduler
  import neuron_step_scheduler_pkg::*;
#(
  parameter int unsigned N_NEURONS = NNeuronsDefault,
  parameter int unsigned W         = WDefault,
  parameter int unsigned TIMEOUT   = TimeoutDefault,
  parameter int          SPIKE_TH  = SpikeThDefault,
  localparam int unsigned IdxW     = idx_width(N_NEURONS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 step_req_i,
  input  logic [W-1:0]         dt_i,
  input  logic                 cur_wr_en_i,
  input  logic [IdxW-1:0]      cur_wr_addr_i,
  input  logic [W-1:0]         cur_wr_data_i,
  output logic                 dp_valid_o,
  input  logic                 dp_ready_i,
  output logic [W-1:0]         dp_v_o,
  output logic [W-1:0]         dp_m_o,
  output logic [W-1:0]         dp_h_o,
  output logic [W-1:0]         dp_n_o,
  output logic [W-1:0]         dp_i_o,
  output logic [W-1:0]         dp_dt_o,
  input  logic                 dp_res_valid_i,
  input  logic [W-1:0]         dp_res_v_i,
  input  logic [W-1:0]         dp_res_m_i,
  input  logic [W-1:0]         dp_res_h_i,
  input  logic [W-1:0]         dp_res_n_i,
  input  logic [IdxW-1:0]      sel_i,
  output logic [W-1:0]         data_out_o,
  output logic                 busy_o,
  output logic                 step_done_o,
  output logic [N_NEURONS-1:0] spike_o,
  output logic                 timeout_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic signed [W-1:0] SpikeTh = W'(SPIKE_TH);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic                 terr_q, terr_d;
  logic [W-1:0]         dt_q;
  logic [W-1:0]         op_v_q, op_m_q, op_h_q, op_n_q, op_i_q;
  logic [W-1:0]         rd_v, rd_m, rd_h, rd_n, rd_i;
  logic                 accept, res_take, timed_out, advance, last_idx, load_op, crossed;

  assign accept    = (state_q == StIdle) && step_req_i;
  assign res_take  = (state_q == StWait) && dp_res_valid_i;
  assign timed_out = (state_q == StWait) && !dp_res_valid_i &&
                     (wait_cnt_q == CntW'(TIMEOUT - 1));
  assign advance   = res_take || timed_out;
  assign last_idx  = (idx_q == IdxW'(N_NEURONS - 1));
  // Operands are snapshotted on entry to ISSUE so a concurrent current write cannot disturb them.
  assign load_op   = accept || (advance && !last_idx);
  assign crossed   = ($signed(op_v_q) < SpikeTh) && ($signed(dp_res_v_i) >= SpikeTh);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (step_req_i) state_d = StIssue;
      StIssue: if (dp_ready_i) state_d = StWait;
      StWait:  if (advance) state_d = last_idx ? StDone : StIssue;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dp_valid_o  = (state_q == StIssue);
    busy_o      = (state_q != StIdle);
    step_done_o = (state_q == StDone);
  end

  always_comb begin
    idx_d      = idx_q;
    spike_d    = spike_q;
    terr_d     = terr_q || timed_out;
    wait_cnt_d = '0;
    if (accept) begin
      idx_d   = '0;
      spike_d = '0;
    end else if (advance && !last_idx) begin
      idx_d = idx_q + IdxW'(1);
    end
    if (res_take && crossed) begin
      spike_d[idx_q] = 1'b1;
    end
    if ((state_q == StWait) && !advance) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      wait_cnt_q <= '0;
      spike_q    <= '0;
      terr_q     <= 1'b0;
      dt_q       <= '0;
      op_v_q     <= '0;
      op_m_q     <= '0;
      op_h_q     <= '0;
      op_n_q     <= '0;
      op_i_q     <= '0;
    end else begin
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      spike_q    <= spike_d;
      terr_q     <= terr_d;
      if (accept) dt_q <= dt_i;
      if (load_op) begin
        op_v_q <= rd_v;
        op_m_q <= rd_m;
        op_h_q <= rd_h;
        op_n_q <= rd_n;
        op_i_q <= rd_i;
      end
    end
  end

  neuron_state_bank #(
    .N_NEURONS (N_NEURONS),
    .W         (W)
  ) u_bank (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_en_i       (res_take),
    .wr_idx_i      (idx_q),
    .wr_v_i        (dp_res_v_i),
    .wr_m_i        (dp_res_m_i),
    .wr_h_i        (dp_res_h_i),
    .wr_n_i        (dp_res_n_i),
    .cur_wr_en_i   (cur_wr_en_i),
    .cur_wr_addr_i (cur_wr_addr_i),
    .cur_wr_data_i (cur_wr_data_i),
    .rd_idx_i      (idx_d),
    .rd_v_o        (rd_v),
    .rd_m_o        (rd_m),
    .rd_h_o        (rd_h),
    .rd_n_o        (rd_n),
    .rd_i_o        (rd_i),
    .sel_i         (sel_i),
    .data_o        (data_out_o)
  );

  assign dp_v_o        = op_v_q;
  assign dp_m_o        = op_m_q;
  assign dp_h_o        = op_h_q;
  assign dp_n_o        = op_n_q;
  assign dp_i_o        = op_i_q;
  assign dp_dt_o       = dt_q;
  assign spike_o       = spike_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler: a scripted datapath stub plus a slot-level
// reference model of V/m/h/n/I, spikes and the sticky timeout flag.
module tb_neuron_step_scheduler;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_req = 1'b0;
  logic [W-1:0]  dt = '0;
  logic          cur_wr_en = 1'b0;
  logic [1:0]    cur_wr_addr = '0;
  logic [W-1:0]  cur_wr_data = '0;
  logic          dp_ready = 1'b0;
  logic          dp_res_valid = 1'b0;
  logic [W-1:0]  dp_res_v = '0, dp_res_m = '0, dp_res_h = '0, dp_res_n = '0;
  logic [1:0]    sel = '0;
  logic          dp_valid, busy, step_done, timeout_err;
  logic [W-1:0]  dp_v, dp_m, dp_h, dp_n, dp_i, dp_dt, data_out;
  logic [N-1:0]  spike;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [W-1:0] mv [N];
  logic [W-1:0]        mm [N], mh [N], mn [N], mi [N];
  logic [N-1:0]        exp_spike;
  logic                exp_terr;

  neuron_step_scheduler #(
    .N_NEURONS (N),
    .W         (W),
    .TIMEOUT   (TO),
    .SPIKE_TH  (0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .step_req_i     (step_req),
    .dt_i           (dt),
    .cur_wr_en_i    (cur_wr_en),
    .cur_wr_addr_i  (cur_wr_addr),
    .cur_wr_data_i  (cur_wr_data),
    .dp_valid_o     (dp_valid),
    .dp_ready_i     (dp_ready),
    .dp_v_o         (dp_v),
    .dp_m_o         (dp_m),
    .dp_h_o         (dp_h),
    .dp_n_o         (dp_n),
    .dp_i_o         (dp_i),
    .dp_dt_o        (dp_dt),
    .dp_res_valid_i (dp_res_valid),
    .dp_res_v_i     (dp_res_v),
    .dp_res_m_i     (dp_res_m),
    .dp_res_h_i     (dp_res_h),
    .dp_res_n_i     (dp_res_n),
    .sel_i          (sel),
    .data_out_o     (data_out),
    .busy_o         (busy),
    .step_done_o    (step_done),
    .spike_o        (spike),
    .timeout_err_o  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic model_init();
    for (int k = 0; k < N; k++) begin
      mv[k] = -16'sd65;
      mm[k] = 16'd0;
      mh[k] = 16'd1;
      mn[k] = 16'd0;
      mi[k] = 16'd0;
    end
    exp_spike = '0;
    exp_terr  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step_req = 1'b0; cur_wr_en = 1'b0; dp_ready = 1'b0; dp_res_valid = 1'b0;
    model_init();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_cur(input int a, input logic [W-1:0] d);
    @(negedge clk);
    cur_wr_en = 1'b1; cur_wr_addr = 2'(a); cur_wr_data = d;
    @(negedge clk);
    cur_wr_en = 1'b0;
    mi[a] = d;
  endtask

  task automatic check_all_v(input string tag);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      sel = 2'(k);
      @(negedge clk);
      n_cmp++;
      if (data_out !== mv[k]) begin
        n_err++;
        $display("FAIL %s_v%0d: data_out=%h required %h", tag, k, data_out, mv[k]);
      end
    end
  endtask

  // kind: 0 random results, 1 V+10 with m/h/n kept, 2 neuron 3 jumps to V=5, others kept
  task automatic run_step(input int rdy_dly, input int res_dly, input int drop_idx, input int kind,
                          input bit chk_stable, input bit wr_in_issue, input bit req_busy);
    logic [6*W-1:0]      ops, exp_ops;
    logic [W-1:0]        cur_dt, rm, rh, rn, new_i;
    logic signed [W-1:0] vold, rv;
    int                  budget, extra;
    @(negedge clk);
    cur_dt = 16'($urandom);
    dt = cur_dt; step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0; dt = 16'($urandom);
    exp_spike = '0;
    for (int k = 0; k < N; k++) begin
      budget = 0;
      while (!dp_valid && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      n_cmp++;
      if (!dp_valid) begin
        n_err++;
        $display("FAIL issue_%0d: dp_valid=%b after %0d cycles, required 1", k, dp_valid, budget);
        return;
      end
      exp_ops = {mv[k], mm[k], mh[k], mn[k], mi[k], cur_dt};
      ops     = {dp_v, dp_m, dp_h, dp_n, dp_i, dp_dt};
      n_cmp++;
      if (ops !== exp_ops) begin
        n_err++;
        $display("FAIL operands_%0d: got %h required %h", k, ops, exp_ops);
      end
      if (wr_in_issue) begin
        new_i = 16'($urandom);
        cur_wr_en = 1'b1; cur_wr_addr = 2'(k); cur_wr_data = new_i;
        mi[k] = new_i;
      end
      for (int s = 0; s < rdy_dly; s++) begin
        dp_ready = 1'b0;
        @(negedge clk);
        cur_wr_en = 1'b0;
        step_req = req_busy && (k == 1) && (s == 0);
        if (chk_stable) begin
          ops = {dp_v, dp_m, dp_h, dp_n, dp_i, dp_dt};
          n_cmp++;
          if (!dp_valid || ops !== exp_ops) begin
            n_err++;
            $display("FAIL stall_%0d_%0d: valid=%b ops=%h required valid=1 ops=%h",
                     k, s, dp_valid, ops, exp_ops);
          end
        end
      end
      step_req = 1'b0;
      dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0; cur_wr_en = 1'b0;
      n_cmp++;
      if (dp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL handshake_%0d: dp_valid=%b required 0", k, dp_valid);
      end
      if (k == drop_idx) begin
        exp_terr = 1'b1;
      end else begin
        repeat (res_dly) @(negedge clk);
        vold = mv[k];
        case (kind)
          1: begin rv = mv[k] + 16'sd10; rm = mm[k]; rh = mh[k]; rn = mn[k]; end
          2: begin rv = (k == 3) ? 16'sd5 : mv[k]; rm = mm[k]; rh = mh[k]; rn = mn[k]; end
          default: begin
            rv = 16'($urandom); rm = 16'($urandom); rh = 16'($urandom); rn = 16'($urandom);
          end
        endcase
        dp_res_valid = 1'b1;
        dp_res_v = rv; dp_res_m = rm; dp_res_h = rh; dp_res_n = rn;
        @(negedge clk);
        dp_res_valid = 1'b0;
        if (vold < 0 && rv >= 0) exp_spike[k] = 1'b1;
        mv[k] = rv; mm[k] = rm; mh[k] = rh; mn[k] = rn;
      end
    end
    budget = 0;
    while (!step_done && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (step_done !== 1'b1) begin
      n_err++;
      $display("FAIL step_done: step_done=%b after %0d cycles, required 1", step_done, budget);
    end
    n_cmp++;
    if (spike !== exp_spike) begin
      n_err++;
      $display("FAIL spike: spike=%b required %b", spike, exp_spike);
    end
    n_cmp++;
    if (timeout_err !== exp_terr || busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_flags: timeout_err=%b busy=%b required %b 1", timeout_err, busy, exp_terr);
    end
    @(negedge clk);
    n_cmp++;
    if (step_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: step_done=%b busy=%b required 0 0", step_done, busy);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || dp_valid) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL idle_after: %0d busy cycles after step, required 0", extra);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    sel = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (data_out !== 16'hFFBF || busy !== 1'b0 || spike !== '0 || timeout_err !== 1'b0 ||
        dp_valid !== 1'b0 || step_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: data_out=%h busy=%b spike=%b terr=%b valid=%b done=%b required ffbf 0 0000 0 0 0",
               data_out, busy, spike, timeout_err, dp_valid, step_done);
    end
    check_all_v("reset");
  endtask

  task automatic test_current_write();
    do_reset();
    write_cur(1, 16'd100);
    run_step(0, 3, -1, 1, 1'b0, 1'b0, 1'b0);
    check_all_v("plus10");
  endtask

  task automatic test_spike();
    do_reset();
    run_step(0, 0, -1, 2, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (spike !== 4'b1000) begin
      n_err++;
      $display("FAIL spike_n3: spike=%b required 1000", spike);
    end
    check_all_v("spike");
  endtask

  task automatic test_timeout();
    do_reset();
    run_step(0, 1, 0, 1, 1'b0, 1'b0, 1'b0);
    check_all_v("timeout");
  endtask

  task automatic test_ready_stall();
    do_reset();
    run_step(5, 1, -1, 0, 1'b1, 1'b0, 1'b1);
    check_all_v("stall");
  endtask

  task automatic test_random();
    int drop;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 3)) write_cur($urandom_range(0, N - 1), 16'($urandom));
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
      run_step($urandom_range(0, 3), $urandom_range(0, 5), drop, 0, 1'b1, it[0], 1'b0);
      check_all_v("random");
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    do_reset();
    write_cur(0, 16'($urandom));
    write_cur(2, 16'($urandom));
    @(negedge clk);
    dt = 16'h0042; step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      budget = 0;
      while (!dp_valid && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      if (k < 2) begin
        dp_res_valid = 1'b1; dp_res_v = 16'h0100;
        @(negedge clk);
        dp_res_valid = 1'b0;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || dp_valid !== 1'b0 || data_out !== 16'hFFBF || spike !== '0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b valid=%b data_out=%h spike=%b required 0 0 ffbf 0000",
               busy, dp_valid, data_out, spike);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    dp_res_valid = 1'b1; dp_res_v = 16'h0200;
    @(negedge clk);
    dp_res_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL late_result: busy=%b required 0", busy);
    end
    check_all_v("post_reset");
    run_step(0, 0, -1, 1, 1'b0, 1'b0, 1'b0);
    check_all_v("post_reset_step");
  endtask

  initial begin
    model_init();
    test_reset();
    test_current_write();
    test_spike();
    test_timeout();
    test_ready_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
